// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Detects load-use
//   hazards, applies taken-branch flushes and freezes the back end while the
//   data memory is busy, with a bounded wait and a sticky timeout flag. Also
//   keeps saturating stall and flush cycle counters.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   idex_MemRead/_rt    load in ID/EX and its destination register
//   ifid_rs/_rt         source registers of the instruction in ID
//   ifid_uses_rt        instruction in ID reads rt
//   ex_branch_taken     branch in EX resolved taken
//   mem_access          EX/MEM holds a load or store
//   mem_ready           data memory completes the access this cycle
//   cnt_clr             synchronous clear of both counters
//   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold   pipeline controls
//   stall_cnt, flush_cnt                                       saturating counters
//   mem_timeout         sticky; a freeze was force-released
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow; no data-memory freeze in progress
// MEM_WAIT | back end frozen waiting on data memory; wcnt = freeze cycles

module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       lu, fr, at_limit, timeout_evt;
  logic       stall_inc, flush_inc;

  always_comb begin
    lu = idex_MemRead && (idex_rt != 5'd0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    // Once the wait has reached its limit the freeze request is dropped, so
    // hold releases in the same cycle the timeout is recorded.
    at_limit    = (state == MEM_WAIT) && (wcnt == TIMEOUT_VAL);
    fr          = mem_access && !mem_ready && !at_limit;
    timeout_evt = at_limit && !mem_ready;
    stall_inc   = fr || (lu && !ex_branch_taken);
    flush_inc   = ex_branch_taken && !fr;
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (fr) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end else begin
          wcnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (fr) begin
          wcnt_nxt = wcnt + 8'd1;
        end else begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // Mealy controls. While in reset the front end is held and a bubble/NOP
  // is injected so no stale instruction escapes on release.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (fr) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (timeout_evt) begin
        mem_timeout <= 1'b1;
      end
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_inc && (stall_cnt != CNT_MAX)) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        if (flush_inc && (flush_cnt != CNT_MAX)) begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It watches the ID/EX, IF/ID and EX/MEM stages and drives the write-enable, flush and bubble controls of the PC and all pipe registers. It handles load-use hazards, taken-branch flushes and variable-latency data-memory freezes, with a bounded wait and a sticky timeout flag. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of stall_cnt and flush_cnt
- MEM_TIMEOUT, 15, maximum consecutive freeze cycles before forced release (1..255)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- idex_MemRead  in  1  MemRead of the instruction held in ID/EX
- idex_rt  in  5  rt field held in ID/EX (load destination)
- ifid_rs  in  5  rs of the instruction in ID
- ifid_rt  in  5  rt of the instruction in ID
- ifid_uses_rt  in  1  instruction in ID reads rt as a source
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mem_access  in  1  EX/MEM holds a load or store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  zero all control inputs of ID/EX
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB (freeze)
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  branch-flush cycles, saturating
- mem_timeout  out  1  sticky; a freeze was force-released

## Operation
- State machine states: RUN, MEM_WAIT. Internal wait counter wcnt has 8 bits.
- Load-use detect (combinational): lu = idex_MemRead & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
- Freeze request: fr = mem_access & ~mem_ready & ~(state == MEM_WAIT & wcnt == MEM_TIMEOUT).
- Priority (combinational outputs), highest first:
  - Freeze (fr = 1): pipe_hold = 1, pc_write = 0, ifid_write = 0, ifid_flush = 0, idex_bubble = 0.
  - Branch (ex_branch_taken = 1): pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_bubble = 1. This overrides lu.
  - Load-use (lu = 1): pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0.
  - Otherwise: pc_write = 1, ifid_write = 1, all other controls 0.
- FSM transitions:
  - RUN -> MEM_WAIT when fr = 1; wcnt <= 1.
  - MEM_WAIT with fr = 1: stay; wcnt <= wcnt + 1.
  - MEM_WAIT with mem_ready = 1: go to RUN; wcnt <= 0.
  - MEM_WAIT with wcnt == MEM_TIMEOUT and mem_ready = 0: go to RUN; wcnt <= 0; mem_timeout <= 1. pipe_hold is already 0 in that cycle.
- Counters (only when reset = 1):
  - cnt_clr has priority and zeroes both counters. It does not clear mem_timeout.
  - stall_cnt += 1 in any cycle with fr, or lu without branch and without fr.
  - flush_cnt += 1 in any cycle with branch taken and no fr.
  - Both counters saturate at 2^CNT_W − 1.
- mem_timeout clears only on reset.

## Timing
- While reset = 0:
  - state = RUN, wcnt = 0, stall_cnt = 0, flush_cnt = 0, mem_timeout = 0.
  - Outputs are forced: pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_bubble = 1, pipe_hold = 0. No branch or stores can occur during reset.
- Reset assertion mid-freeze abandons MEM_WAIT immediately (asynchronous). After release the block starts in RUN.
- Control outputs have zero latency (Mealy); registered state affects them from the next edge.
- A load-use stall lasts exactly one cycle: the bubble clears idex_MemRead at the next edge, so lu drops.
- A freeze holds for the cycles where mem_ready = 0, up to MEM_TIMEOUT cycles. If the timeout is reached, hold is released on cycle MEM_TIMEOUT+1.
- A new freeze may begin the cycle after a release; there is no dead cycle.
- A branch coinciding with a freeze is deferred: ex_branch_taken remains valid because ID/EX is held, and the flush is applied on the release cycle.

## Test plan
- **Load-use hazard.** Drive idex_MemRead = 1, idex_rt = 5, ifid_rs = 5 for 1 cycle. Expect pc_write = 0, ifid_write = 0, idex_bubble = 1, and stall_cnt goes 0 -> 1. Repeat with idex_rt = 0, or with ifid_rt = 5 and ifid_uses_rt = 0: expect no stall.
- **Branch overrides load-use.** Drive ex_branch_taken = 1 with lu = 1. Expect ifid_flush = 1, idex_bubble = 1, pc_write = 1; flush_cnt = 1 and stall_cnt = 0.
- **Normal freeze.** Hold mem_access = 1 with mem_ready = 0 for 3 cycles, then 1. Expect pipe_hold = 1 for 3 cycles and 0 on the 4th; state returns to RUN; stall_cnt = 3; mem_timeout = 0.
- **Timeout.** With MEM_TIMEOUT = 4, hold mem_ready = 0 indefinitely. Expect pipe_hold = 1 for 4 cycles, then 0, with mem_timeout = 1 after the 5th edge. Confirm mem_timeout stays 1 through cnt_clr.
- **Saturation and clear.** With CNT_W = 3, force 10 consecutive stalls. Expect stall_cnt to stop at 7; then pulse cnt_clr and expect 0.
- **Reset mid-freeze.** Drop reset low during MEM_WAIT. Expect all counters and flags to go to 0 immediately, ifid_flush = 1 and idex_bubble = 1 while reset is low, and RUN behaviour after release.
